// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode helper for the pipelined ALU.
package alu_pkg;

    // Opcode map kept identical to the original combinational datapath ALU.
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SLL  = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_SLTU = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    // Control FSM states: waiting, multiply iterating, result held.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Opcodes above MUL are undefined and complete with result 0 and illegal set.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: WIDTH steps, one partial product per cycle.
// done is high during the final step; product is valid while done is high.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_next;

    // Accumulator value after the current step; becomes the product on the last step.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = (count == CW'(1));
    assign product  = acc_next;

    // Load operands on start, then shift multiplicand left and multiplier right each step.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            count  <= CW'(WIDTH);
        end else if (count != '0) begin
            acc    <= acc_next;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and flags; MUL runs on the iterative multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_decode,
    input  logic [WIDTH-1:0] rda,
    input  logic [WIDTH-1:0] rdx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic [1:0]       state;
    logic             accept;
    logic             is_mul;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] op_result;
    logic             op_overflow;
    logic             op_illegal;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_decode == OP_MUL);
    assign shamt     = rda[SHW-1:0];
    assign sum       = rdx + rda;
    assign diff      = rdx - rda;
    assign op_illegal = !is_legal_op(alu_decode);

    // Single-cycle operations and their signed-overflow flag.
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        op_result   = '0;
        op_overflow = 1'b0;
        case (alu_decode)
            OP_AND:  op_result = rda & rdx;
            OP_OR:   op_result = rda | rdx;
            OP_ADD: begin
                op_result   = sum;
                op_overflow = (rda[WIDTH-1] == rdx[WIDTH-1]) && (sum[WIDTH-1] != rdx[WIDTH-1]);
            end
            OP_SLL:  op_result = rdx << shamt;
            OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(rdx) < $signed(rda))};
            OP_SLTU: op_result = {{(WIDTH-1){1'b0}}, (rdx < rda)};
            OP_SUB: begin
                op_result   = diff;
                op_overflow = (rdx[WIDTH-1] != rda[WIDTH-1]) && (diff[WIDTH-1] != rdx[WIDTH-1]);
            end
            OP_XOR:  op_result = rda ^ rdx;
            OP_SRL:  op_result = rdx >> shamt;
            OP_SRA:  op_result = $signed(rdx) >>> shamt;
            default: op_result = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (accept && is_mul),
        .multiplicand (rdx),
        .multiplier   (rda),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Control FSM and result/flag registers; results hold until the consumer takes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_BUSY;
                        end else begin
                            state    <= ST_DONE;
                            result   <= op_result;
                            zero     <= (op_result == '0);
                            overflow <= op_overflow;
                            illegal  <= op_illegal;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state    <= ST_DONE;
                        result   <= mul_product;
                        zero     <= (mul_product == '0);
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_decode = 4'h0;
    logic [W-1:0] rda = '0;
    logic [W-1:0] rdx = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_decode (alu_decode),
        .rda        (rda),
        .rdx        (rdx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the opcode rules.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] a);
        exp_t        e;
        longint      sx, sa, s;
        logic [63:0] ux, ua, w;
        int          sh;
        sx = $signed(x);
        sa = $signed(a);
        ux = {32'h0, x};
        ua = {32'h0, a};
        sh = int'(a % 32);
        e  = '0;
        case (op)
            4'h0: e.res = x & a;
            4'h1: e.res = x | a;
            4'h2: begin
                w = ux + ua; e.res = w[31:0];
                s = sx + sa; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h3: begin w = ux << sh; e.res = w[31:0]; end
            4'h4: e.res = (sx < sa) ? 32'd1 : 32'd0;
            4'h5: e.res = (ux < ua) ? 32'd1 : 32'd0;
            4'h6: begin
                w = ux - ua; e.res = w[31:0];
                s = sx - sa; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h7: e.res = x ^ a;
            4'h8: begin w = ux >> sh; e.res = w[31:0]; end
            4'h9: begin s = sx >>> sh; e.res = s[31:0]; end
            4'hA: begin w = ux * ua; e.res = w[31:0]; end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    function automatic logic [35:0] outs();
        return {out_valid, result, zero, overflow, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] a);
        in_valid   = 1'b1;
        alu_decode = op;
        rdx        = x;
        rda        = a;
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        reset = 1'b0;
        repeat (3) step();
        obs = {in_ready, outs()};
        checks++;
        if (obs !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 1'b0, 32'h0, 3'b000});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [35:0] exp_v [3];
        logic [3:0]  ops [3];
        logic [31:0] xs [3];
        logic [31:0] as_ [3];
        ops[0] = OP_ADD; xs[0] = 32'h7FFFFFFF; as_[0] = 32'h1; exp_v[0] = {1'b1, 32'h80000000, 3'b010};
        ops[1] = OP_SUB; xs[1] = 32'h5;        as_[1] = 32'h7; exp_v[1] = {1'b1, 32'hFFFFFFFE, 3'b000};
        ops[2] = OP_SLT; xs[2] = 32'hFFFFFFFF; as_[2] = 32'h1; exp_v[2] = {1'b1, 32'h00000001, 3'b000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], xs[i], as_[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            checks++;
            if (outs() !== exp_v[i]) begin
                errors++;
                $display("FAIL basic_op[%0d]: got %h expected %h", i, outs(), exp_v[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_shifts();
        drive(OP_SRA, 32'h80000000, 32'h24);
        step();
        checks++;
        if (outs() !== {1'b1, 32'hF8000000, 3'b000}) begin
            errors++;
            $display("FAIL sra: got %h expected %h", outs(), {1'b1, 32'hF8000000, 3'b000});
        end
        drive(OP_SRL, 32'h80000000, 32'h24);
        step();
        checks++;
        if (outs() !== {1'b1, 32'h08000000, 3'b000}) begin
            errors++;
            $display("FAIL srl: got %h expected %h", outs(), {1'b1, 32'h08000000, 3'b000});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int busy_bad = 0;
        drive(OP_MUL, 32'h00012345, 32'h00000100);
        step();
        // Offer a different op with scrambled operands while busy; it must be ignored.
        drive(OP_AND, 32'hDEADBEEF, 32'h12345678);
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
            rdx = $urandom;
            rda = $urandom;
            if (i == 31) in_valid = 1'b0;
            step();
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL mul_busy: %0d cycles with in_ready/out_valid set, expected 0", busy_bad);
        end
        checks++;
        if (outs() !== {1'b1, 32'h01234500, 3'b000}) begin
            errors++;
            $display("FAIL mul_result: got %h expected %h", outs(), {1'b1, 32'h01234500, 3'b000});
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int hold_bad = 0;
        out_ready = 1'b0;
        drive(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0);
        step();
        drive(OP_ADD, 32'h1, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (outs() !== {1'b1, 32'h00F000F0, 3'b000} || in_ready !== 1'b0) hold_bad++;
            step();
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, expected 0 (last %h)", hold_bad, outs());
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (outs() !== {1'b1, 32'h00000002, 3'b000}) begin
            errors++;
            $display("FAIL bp_next_op: got %h expected %h", outs(), {1'b1, 32'h00000002, 3'b000});
        end
        step();
    endtask

    task automatic test_illegal();
        drive(4'hC, 32'h1, 32'h1);
        step();
        in_valid = 1'b0;
        checks++;
        if (outs() !== {1'b1, 32'h0, 3'b101}) begin
            errors++;
            $display("FAIL illegal_op: got %h expected %h", outs(), {1'b1, 32'h0, 3'b101});
        end
        checks++;
        if ($isunknown({in_ready, outs()})) begin
            errors++;
            $display("FAIL illegal_no_x: got %h expected no X", {in_ready, outs()});
        end
        step();
    endtask

    task automatic test_reset_during_mul();
        int ghost = 0;
        drive(OP_MUL, 32'hFFFF1234, 32'h00AB00CD);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rst_mul_abort: got %h expected %h", {out_valid, in_ready, result}, {1'b0, 1'b1, 32'h0});
        end
        step();
        step();
        reset = 1'b1;
        step();
        drive(OP_ADD, 32'h2, 32'h3);
        step();
        in_valid = 1'b0;
        checks++;
        if (outs() !== {1'b1, 32'h5, 3'b000}) begin
            errors++;
            $display("FAIL rst_add_after: got %h expected %h", outs(), {1'b1, 32'h5, 3'b000});
        end
        step();
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) ghost++;
            step();
        end
        checks++;
        if (ghost != 0) begin
            errors++;
            $display("FAIL rst_no_ghost: out_valid seen %0d cycles, expected 0", ghost);
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [5];
        logic [3:0]  op;
        logic [31:0] x, a;
        exp_t        e;
        int          n, hold, want_lat;
        edge_vals[0] = 32'h0;
        edge_vals[1] = 32'h1;
        edge_vals[2] = 32'h7FFFFFFF;
        edge_vals[3] = 32'h80000000;
        edge_vals[4] = 32'hFFFFFFFF;
        for (int t = 0; t < 60; t++) begin
            op = 4'($urandom_range(0, 15));
            x  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            a  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            e  = model(op, x, a);
            out_ready = 1'b1;
            drive(op, x, a);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected 1", t, in_ready);
            end
            step();
            in_valid = 1'b0;
            rdx = $urandom;
            rda = $urandom;
            n = 0;
            while (out_valid !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            want_lat = (op == OP_MUL) ? 32 : 0;
            checks++;
            if (n != want_lat) begin
                errors++;
                $display("FAIL rand_latency[%0d] op %h: got %0d extra cycles expected %0d", t, op, n, want_lat);
            end
            out_ready = 1'b0;
            hold = $urandom_range(0, 2);
            repeat (hold) step();
            checks++;
            if (outs() !== {1'b1, e}) begin
                errors++;
                $display("FAIL rand_op[%0d] op %h x %h a %h: got %h expected %h", t, op, x, a, outs(), {1'b1, e});
            end
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_shifts();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_during_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
